iram_cache: RTL
===============

# iram_cache

Parametrised microcode-store front end for the CADR core. It replaces the flat on-chip IRAM with a direct-mapped, one-word-per-line cache of an external microcode memory. Fetches that hit return in two cycles. Misses and all microcode writes go to the external store over a request/ready handshake, and writes are write-through and write-allocate. The block sits between the sequencer (`pc`, `iwr`, `iwe`) and the external MCR memory controller.

## Interface
Parameters:
- `ADDR_WIDTH`, 14: microcode address width.
- `DATA_WIDTH`, 49: microinstruction width.
- `LINES`, 256: cache lines. Must be a power of two, at least 2 and at most 2^ADDR_WIDTH. `IDX = log2(LINES)`, `TAG = ADDR_WIDTH - IDX`.

Ports:
- `clk` in 1: the single clock; everything is on the rising edge.
- `reset` in 1: synchronous, active-low. 0 sampled on an edge means reset.
- `pc` in ADDR_WIDTH: fetch or write address.
- `fetch` in 1: read request; sampled only while `busy`=0.
- `iwr` in DATA_WIDTH: write data.
- `iwe` in 1: write request; sampled only while `busy`=0.
- `invalidate` in 1: clear all valid bits.
- `iram` out DATA_WIDTH: microinstruction, registered; holds its value until the next return.
- `iram_valid` out 1: one-cycle pulse when `iram` is updated for a fetch.
- `busy` out 1: high whenever state is not IDLE.
- `mcr_req` out 1: external request.
- `mcr_write` out 1: 1 for a write request, 0 for a read request.
- `mcr_addr` out ADDR_WIDTH: external address.
- `mcr_data_out` out DATA_WIDTH: external write data.
- `mcr_data_in` in DATA_WIDTH: external read data; valid when `mcr_ready`=1.
- `mcr_ready` in 1: external completion strobe.

## Operation
Storage:
- Data array: `LINES` x `DATA_WIDTH`.
- Tag array: `LINES` x `TAG`.
- Valid bits: `LINES` x 1.
- Index is `pc[IDX-1:0]`; tag is `pc[ADDR_WIDTH-1:IDX]`.
- Arrays use synchronous read and must infer block RAM. Valid bits are in flops.

States: FLUSH, IDLE, LOOKUP, MISS, WRITE.
- **FLUSH**
  - Entered on reset, or from IDLE when `invalidate` or `inv_pending` is set.
  - A counter clears one valid bit per cycle, index 0 up to `LINES`-1, then moves to IDLE.
  - Clears `inv_pending` on entry.
- **IDLE**
  - Priority: invalidate/`inv_pending` > `iwe` > `fetch`.
  - A lower-priority request in the same cycle is dropped; the sequencer re-issues it after `busy` falls.
  - On `iwe`: latch `pc` and `iwr`; write the data, tag and valid bit of the line; go to WRITE.
  - On `fetch`: latch `pc`; address the arrays; go to LOOKUP.
- **LOOKUP**
  - Hit (valid and tag equal): `iram` gets the array data, pulse `iram_valid`, go to IDLE.
  - Miss: go to MISS.
- **MISS**
  - `mcr_req`=1, `mcr_write`=0, `mcr_addr` = latched pc.
  - On the edge where `mcr_ready`=1: write `mcr_data_in`, the tag and the valid bit into the line; `iram` gets `mcr_data_in`; pulse `iram_valid`; go to IDLE.
- **WRITE**
  - `mcr_req`=1, `mcr_write`=1, `mcr_addr` = latched pc, `mcr_data_out` = latched data.
  - On `mcr_ready`=1, go to IDLE.
  - No `iram_valid` pulse.

Rules and boundary conditions:
- While `mcr_req`=1, the signals `mcr_addr`, `mcr_write` and `mcr_data_out` are constant.
- `mcr_req` drops on the cycle after ready is sampled.
- `mcr_ready` outside MISS/WRITE is ignored.
- `invalidate` while not IDLE sets `inv_pending`. The current transaction completes first, including the line fill, and FLUSH follows immediately.
- `invalidate` during FLUSH is absorbed; no second flush is performed.
- Index wrap-around: addresses with equal index but different tag evict each other.

## Timing
Reset values:
- `iram`=0, `iram_valid`=0, `mcr_req`=0, `mcr_write`=0, `mcr_addr`=0, `mcr_data_out`=0.
- `busy`=1: FLUSH starts with the counter at 0, and `busy` falls after exactly `LINES` cycles of deasserted reset.

Reset mid-transaction:
- `mcr_req` is 0 on the cycle after the reset edge.
- The line is not filled, and `inv_pending` clears.

Latencies:
- Hit: `fetch` sampled at edge N, `iram_valid`=1 in the cycle after edge N+2, `busy` low again at the same time.
- Miss: ready sampled at edge M, `iram_valid`=1 in the cycle after edge M. With `mcr_ready` held at 1, a miss costs 3 edges.
- Write: `busy` is high from edge N+1 until the edge after ready is sampled.

## Test plan
- **Reset flush.** `LINES`=256. Release reset: `busy`=1 for 256 cycles, then 0; all mcr outputs stay 0.
- **Cold miss then hit.** Fetch pc=0x0123, external returns 0x1_2345_6789_ABCD after 5 wait cycles: `mcr_req` high for 6 cycles with `mcr_addr`=0x0123, `iram` matches the returned word with one `iram_valid` pulse. Re-fetch 0x0123: `iram_valid` 2 cycles later and no `mcr_req`.
- **Write-through.** `iwe` at pc=0x0040 with `iwr`=0x0_0000_DEAD_BEEF: `mcr_write`=1 with that data until ready. Then fetch 0x0040: hit returning 0x0_0000_DEAD_BEEF, no external read.
- **Aliasing.** Fetch 0x0005, fetch 0x0105, then fetch 0x0005 again: three misses, and each external read uses the correct address.
- **Simultaneous events.** `iwe`+`fetch` in the same cycle: only the write occurs. `invalidate` during MISS: the fill completes with an `iram_valid` pulse, then 256 cycles of FLUSH, and the next fetch of the same pc misses.
- **Reset mid-miss.** Pull `reset` low while `mcr_req`=1: `mcr_req`=0 on the next cycle. After the flush, a fetch of the same pc misses.

Source files
------------

// File: rtl/iram_cache_if.sv
// External microcode-store bus between iram_cache (master) and the MCR memory controller (slave).
// A request is held until the controller strobes mcr_ready for one cycle.
interface iram_cache_if #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 49
);
    logic                  mcr_req;
    logic                  mcr_write;
    logic [ADDR_WIDTH-1:0] mcr_addr;
    logic [DATA_WIDTH-1:0] mcr_data_out;
    logic [DATA_WIDTH-1:0] mcr_data_in;
    logic                  mcr_ready;

    modport master (
        output mcr_req, mcr_write, mcr_addr, mcr_data_out,
        input  mcr_data_in, mcr_ready
    );

    modport slave (
        input  mcr_req, mcr_write, mcr_addr, mcr_data_out,
        output mcr_data_in, mcr_ready
    );
endinterface

// File: rtl/iram_cache.sv
// Direct-mapped, one-word-per-line microcode cache in front of the external MCR store.
// Write-through / write-allocate; hits return two edges after the fetch is sampled.
module iram_cache #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 49,
    parameter int LINES      = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] pc,
    input  logic                  fetch,
    input  logic [DATA_WIDTH-1:0] iwr,
    input  logic                  iwe,
    input  logic                  invalidate,
    output logic [DATA_WIDTH-1:0] iram,
    output logic                  iram_valid,
    output logic                  busy,
    iram_cache_if.master          mcr
);
    localparam int IDX = $clog2(LINES);
    localparam int TAG = ADDR_WIDTH - IDX;
    localparam int TW  = (TAG > 0) ? TAG : 1;

    typedef enum logic [2:0] {FLUSH, IDLE, LOOKUP, MISS, WRITE} state_t;

    state_t                state;
    logic [IDX-1:0]        cnt;
    logic                  inv_pending;
    logic                  lk_wait;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [LINES-1:0]      valid;

    logic [DATA_WIDTH-1:0] data_mem [LINES];
    logic [TW-1:0]         tag_mem  [LINES];
    logic [DATA_WIDTH-1:0] rd_data;
    logic [TW-1:0]         rd_tag;

    logic [IDX-1:0]        pc_idx, q_idx, w_idx;
    logic [TW-1:0]         pc_tag, q_tag, w_tag;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  start_inv, take_write, take_fetch, fill, ram_we, hit;

    assign pc_idx = pc[IDX-1:0];
    assign q_idx  = pc_q[IDX-1:0];

    generate
        if (TAG > 0) begin : g_tag
            assign pc_tag = pc[ADDR_WIDTH-1:IDX];
            assign q_tag  = pc_q[ADDR_WIDTH-1:IDX];
        end else begin : g_notag
            assign pc_tag = '0;
            assign q_tag  = '0;
        end
    endgenerate

    assign start_inv  = invalidate | inv_pending;
    assign take_write = (state == IDLE) && !start_inv && iwe;
    assign take_fetch = (state == IDLE) && !start_inv && !iwe && fetch;
    assign fill       = (state == MISS) && mcr.mcr_ready;
    // Reset must win over a fill landing on the same edge.
    assign ram_we     = reset && (take_write || fill);
    assign w_idx      = take_write ? pc_idx : q_idx;
    assign w_tag      = take_write ? pc_tag : q_tag;
    assign w_data     = take_write ? iwr : mcr.mcr_data_in;
    assign hit        = valid[q_idx] && (rd_tag == q_tag);
    assign busy       = (state != IDLE);

    // Simple dual-port arrays: one write port, one registered read port.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            data_mem[w_idx] <= w_data;
            tag_mem[w_idx]  <= w_tag;
        end
        rd_data <= data_mem[q_idx];
        rd_tag  <= tag_mem[q_idx];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state            <= FLUSH;
            cnt              <= '0;
            inv_pending      <= 1'b0;
            lk_wait          <= 1'b0;
            pc_q             <= '0;
            iram             <= '0;
            iram_valid       <= 1'b0;
            mcr.mcr_req      <= 1'b0;
            mcr.mcr_write    <= 1'b0;
            mcr.mcr_addr     <= '0;
            mcr.mcr_data_out <= '0;
        end else begin
            iram_valid <= 1'b0;
            if (invalidate && state != IDLE && state != FLUSH)
                inv_pending <= 1'b1;
            case (state)
                FLUSH: begin
                    valid[cnt] <= 1'b0;
                    cnt        <= cnt + 1'b1;
                    if (&cnt)
                        state <= IDLE;
                end
                IDLE: begin
                    if (start_inv) begin
                        cnt         <= '0;
                        inv_pending <= 1'b0;
                        state       <= FLUSH;
                    end else if (take_write) begin
                        pc_q             <= pc;
                        valid[pc_idx]    <= 1'b1;
                        mcr.mcr_req      <= 1'b1;
                        mcr.mcr_write    <= 1'b1;
                        mcr.mcr_addr     <= pc;
                        mcr.mcr_data_out <= iwr;
                        state            <= WRITE;
                    end else if (take_fetch) begin
                        pc_q    <= pc;
                        lk_wait <= 1'b1;
                        state   <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    // First cycle only waits for the registered array read of pc_q.
                    if (lk_wait) begin
                        lk_wait <= 1'b0;
                    end else if (hit) begin
                        iram       <= rd_data;
                        iram_valid <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        mcr.mcr_req   <= 1'b1;
                        mcr.mcr_write <= 1'b0;
                        mcr.mcr_addr  <= pc_q;
                        state         <= MISS;
                    end
                end
                MISS: begin
                    if (mcr.mcr_ready) begin
                        valid[q_idx] <= 1'b1;
                        iram         <= mcr.mcr_data_in;
                        iram_valid   <= 1'b1;
                        mcr.mcr_req  <= 1'b0;
                        state        <= IDLE;
                    end
                end
                WRITE: begin
                    if (mcr.mcr_ready) begin
                        mcr.mcr_req <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= FLUSH;
            endcase
        end
    end
endmodule
